// File: rtl/opm_pkg.sv
// opm_pkg: shared widths, window record and FSM state for the opm window reader
package opm_pkg;
  localparam int OPM_IN_W = 10;
  localparam int OPM_WIN_LOG = 4;
  localparam int SUM_W = OPM_IN_W + OPM_WIN_LOG;
  localparam int CNT_W = OPM_WIN_LOG + 1;
  typedef struct packed {
    logic [SUM_W-1:0]    sum;
    logic [OPM_IN_W-1:0] peak;
    logic [CNT_W-1:0]    cnt;
    logic                over;
  } opm_rec_t;
  typedef enum logic {S_IDLE, S_RUN} opm_state_t;
endpackage

// File: rtl/opm_rec_fifo.sv
// opm_rec_fifo: first-word fall-through FIFO of window records
module opm_rec_fifo import opm_pkg::*; #(
  parameter int FIFO_LOG = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  opm_rec_t din,
  output opm_rec_t dout,
  output logic     full,
  output logic     empty
);
  logic [FIFO_LOG:0] wp, rp;
  opm_rec_t mem [2**FIFO_LOG];
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {FIFO_LOG{1'b0}}};
  assign do_pop = pop && !empty;
  // a pop in the same cycle frees the slot, so a push while full still lands
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp[FIFO_LOG-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{FIFO_LOG{1'b0}}, do_push};
      rp <= rp + {{FIFO_LOG{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[FIFO_LOG-1:0]] <= din;
endmodule

// File: rtl/opm_window_reader.sv
// opm_window_reader: windowed sum/peak of the opm power word, queued as records
module opm_window_reader import opm_pkg::*; #(
  parameter int IN_W     = OPM_IN_W,
  parameter int WIN_LOG  = OPM_WIN_LOG,
  parameter int FIFO_LOG = 2,
  parameter int DROP_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    en,
  input  logic [IN_W-1:0]         pwr_in,
  input  logic [IN_W+WIN_LOG-1:0] thresh,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [IN_W+WIN_LOG-1:0] m_sum,
  output logic [IN_W-1:0]         m_peak,
  output logic [WIN_LOG:0]        m_cnt,
  output logic                    m_over,
  output logic                    busy,
  output logic [DROP_W-1:0]       drop_cnt
);
  opm_state_t st, nxt;
  logic [SUM_W-1:0] sum, nsum;
  logic [IN_W-1:0] peak, npeak;
  logic [CNT_W-1:0] cnt, ncnt;
  logic run, push, clr, pop, full, empty, drop;
  opm_rec_t rec, head;
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= S_IDLE;
    else st <= nxt;
  always_comb begin
    run = st == S_RUN;
    nsum = sum + SUM_W'(en ? pwr_in : '0);
    npeak = (en && pwr_in > peak) ? pwr_in : peak;
    ncnt = cnt + CNT_W'(en);
    push = run && (ncnt[WIN_LOG] || (stop && ncnt != '0));
    clr = (!run && start) || push;
    nxt = run ? (stop ? S_IDLE : S_RUN) : (start ? S_RUN : S_IDLE);
    rec = '{sum: nsum, peak: npeak, cnt: ncnt, over: nsum > thresh};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum <= '0;
      peak <= '0;
      cnt <= '0;
    end else if (clr) begin
      sum <= '0;
      peak <= '0;
      cnt <= '0;
    end else if (run && en) begin
      sum <= nsum;
      peak <= npeak;
      cnt <= ncnt;
    end
  assign pop = m_valid && m_ready;
  assign drop = push && full && !pop;
  opm_rec_fifo #(.FIFO_LOG(FIFO_LOG)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(rec),
    .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  assign m_valid = !empty;
  assign m_sum = m_valid ? head.sum : '0;
  assign m_peak = m_valid ? head.peak : '0;
  assign m_cnt = m_valid ? head.cnt : '0;
  assign m_over = m_valid && head.over;
  assign busy = run;
endmodule

// File: tb/tb_opm_window_reader.sv
// tb_opm_window_reader: directed checks of windowing, flush, backpressure and reset
module tb_opm_window_reader;
  logic clk = 0, rst = 0, start = 0, stop = 0, en = 0, m_ready = 0;
  logic [9:0] pwr_in = 0;
  logic [13:0] thresh = 0;
  logic m_valid, m_over, busy;
  logic [13:0] m_sum;
  logic [9:0] m_peak;
  logic [4:0] m_cnt;
  logic [7:0] drop_cnt;
  int errs = 0, n = 0;
  opm_window_reader dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .pwr_in(pwr_in),
    .thresh(thresh), .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum),
    .m_peak(m_peak), .m_cnt(m_cnt), .m_over(m_over), .busy(busy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic samp(input int v);
    en = 1;
    pwr_in = 10'(v);
    step();
    en = 0;
  endtask
  task automatic go();
    start = 1;
    step();
    start = 0;
  endtask
  task automatic chk_rec(input string tag, input int s, input int p, input int c, input int o);
    chk({tag, ".valid"}, m_valid, 1);
    chk({tag, ".sum"}, m_sum, s);
    chk({tag, ".peak"}, m_peak, p);
    chk({tag, ".cnt"}, m_cnt, c);
    chk({tag, ".over"}, m_over, o);
  endtask
  task automatic pop1();
    m_ready = 1;
    step();
    m_ready = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, m_valid, 0);
    chk({tag, ".sum"}, m_sum, 0);
    chk({tag, ".peak"}, m_peak, 0);
    chk({tag, ".cnt"}, m_cnt, 0);
    chk({tag, ".over"}, m_over, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".drop"}, drop_cnt, 0);
  endtask
  initial begin
    #2 rst = 1;
    step();
    step();
    chk_zero("reset");
    rst = 0;
    go();
    chk("busy_rise", busy, 1);
    thresh = 100;
    for (int i = 0; i < 15; i++) samp(5);
    chk("full_not_yet", m_valid, 0);
    samp(5);
    chk_rec("full", 80, 5, 16, 0);
    pop1();
    chk("full_popped", m_valid, 0);
    thresh = 135;
    for (int i = 1; i <= 16; i++) samp(i);
    chk_rec("ramp135", 136, 16, 16, 1);
    pop1();
    thresh = 136;
    for (int i = 1; i <= 16; i++) samp(i);
    chk_rec("ramp136", 136, 16, 16, 0);
    pop1();
    for (int i = 0; i < 5; i++) samp(7);
    chk("part_not_yet", m_valid, 0);
    stop = 1;
    step();
    stop = 0;
    chk("part_busy", busy, 0);
    chk_rec("part", 35, 7, 5, 0);
    pop1();
    go();
    stop = 1;
    step();
    stop = 0;
    chk("empty_stop_rec", m_valid, 0);
    chk("empty_stop_busy", busy, 0);
    go();
    for (int i = 0; i < 15; i++) samp(2);
    stop = 1;
    samp(2);
    stop = 0;
    chk_rec("stop_last", 32, 2, 16, 0);
    chk("stop_last_busy", busy, 0);
    pop1();
    chk("stop_last_one", m_valid, 0);
    go();
    for (int w = 1; w <= 6; w++)
      for (int i = 0; i < 16; i++) samp(w);
    chk("bp_drop", drop_cnt, 2);
    chk_rec("bp_head", 16, 1, 16, 0);
    m_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d.valid", i), m_valid, 1);
      chk($sformatf("drain%0d.sum", i), m_sum, 16 * i);
      step();
    end
    m_ready = 0;
    chk("drain_done", m_valid, 0);
    stop = 1;
    step();
    stop = 0;
    chk("bp_stop_norec", m_valid, 0);
    go();
    for (int i = 0; i < 32; i++) samp(3);
    for (int i = 0; i < 9; i++) samp(9);
    chk_rec("pre_rst", 48, 3, 16, 0);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1;
    #1 chk_zero("async_rst");
    #1 rst = 0;
    go();
    for (int i = 0; i < 15; i++) samp(4);
    chk("fresh_not_yet", m_valid, 0);
    samp(4);
    chk_rec("fresh", 64, 4, 16, 0);
    pop1();
    chk("fresh_popped", m_valid, 0);
    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end
endmodule
